// File: rtl/vram_port_arbiter.sv
// Single-port character RAM arbiter: scanout reads take priority, then the
// clear-screen sweep, then buffered CPU writes drained from a small FIFO.
module vram_port_arbiter #(
    parameter int HTILES     = 80,
    parameter int VTILES     = 60,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [7:0]        cpu_wr_data,
    output logic              cpu_wr_drop,
    input  logic              clr_start,
    input  logic [7:0]        clr_char,
    output logic              clr_busy,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_data,
    output logic              disp_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int N_TILES = HTILES * VTILES;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W:0]   N_EXT     = (ADDR_W + 1)'(N_TILES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TILES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_next;
    logic [7:0]        r_clr_char, w_clr_char_next;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_next;
    logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_next;
    logic [CNT_W-1:0]  r_count, w_count_next;

    logic              r_ready;
    logic              r_drop;
    logic              r_disp_pend;
    logic              r_disp_valid;
    logic [7:0]        r_disp_data;

    logic              w_accept;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;

    assign w_accept   = cpu_wr_valid && r_ready;
    assign w_in_range = ({1'b0, cpu_wr_addr} < N_EXT);
    // A clear starting this cycle overwrites everything, so a coincident accept is discarded.
    assign w_push     = w_accept && w_in_range && !w_flush;

    always_comb begin
        w_state_next    = r_state;
        w_clr_cnt_next  = r_clr_cnt;
        w_clr_char_next = r_clr_char;
        w_flush         = 1'b0;
        w_pop           = 1'b0;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = '0;
        ram_wdata       = '0;

        if (!rst) begin
            if (disp_req) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end else if (r_state == ST_CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_clr_cnt;
                ram_wdata = r_clr_char;
            end else if (r_count != '0) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_fifo_addr[r_rd_ptr];
                ram_wdata = r_fifo_data[r_rd_ptr];
                w_pop     = 1'b1;
            end
        end

        if (r_state == ST_IDLE) begin
            if (clr_start) begin
                w_state_next    = ST_CLEAR;
                w_clr_cnt_next  = '0;
                w_clr_char_next = clr_char;
                w_flush         = 1'b1;
            end
        end else begin
            // Scanout-stolen cycles leave the sweep position untouched.
            if (!disp_req) begin
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (w_flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                w_count_next = r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_wr_addr;
            r_fifo_data[r_wr_ptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_clr_char   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ready      <= 1'b0;
            r_drop       <= 1'b0;
            r_disp_pend  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_clr_cnt    <= w_clr_cnt_next;
            r_clr_char   <= w_clr_char_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_count      <= w_count_next;
            // Ready is computed from next-cycle occupancy so it never needs a combinational path from the pop.
            r_ready      <= (w_count_next < DEPTH_C) && (w_state_next == ST_IDLE);
            r_drop       <= w_accept && !w_in_range;
            r_disp_pend  <= disp_req;
            r_disp_valid <= r_disp_pend;
            if (r_disp_pend) begin
                r_disp_data <= ram_rdata;
            end
        end
    end

    assign cpu_wr_ready = r_ready;
    assign cpu_wr_drop  = r_drop;
    assign clr_busy     = (r_state == ST_CLEAR);
    assign disp_data    = r_disp_data;
    assign disp_valid   = r_disp_valid;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: queue-based model of the write
// buffer, fetch latency and clear sweep, with a behavioural RAM behind the DUT.
module tb_vram_port_arbiter;

    localparam int HT    = 80;
    localparam int VT    = 60;
    localparam int AW    = 13;
    localparam int DEPTH = 4;
    localparam int N     = HT * VT;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_wr_valid = 1'b0;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [7:0]    cpu_wr_data = '0;
    logic          cpu_wr_drop;
    logic          clr_start = 1'b0;
    logic [7:0]    clr_char = '0;
    logic          clr_busy;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [7:0]    disp_data;
    logic          disp_valid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]    ram_mem [MEMSZ];
    logic [7:0]    ref_mem [MEMSZ];
    logic [AW-1:0] wq_addr [$];
    logic [7:0]    wq_data [$];
    int            dq_due  [$];
    logic [7:0]    dq_data [$];

    vram_port_arbiter #(
        .HTILES(HT), .VTILES(VT), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_drop(cpu_wr_drop),
        .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] v;
        v = 8'(i * 73 + 19);
        return v ^ 8'(i >> 3);
    endfunction

    // Behavioural single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < MEMSZ; i++) ram_mem[i] <= init_byte(i);
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [34:0] outs;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = AW'($urandom_range(0, N - 1));
            disp_req     = 1'b1;
            disp_addr    = AW'($urandom_range(0, N - 1));
            clr_start    = 1'b1;
            #1;
            outs = {cpu_wr_ready, cpu_wr_drop, clr_busy, disp_valid, disp_data,
                    ram_en, ram_we, ram_addr, ram_wdata};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, outs);
            end
        end
        next_cycle();
        rst = 1'b0; cpu_wr_valid = 1'b0; disp_req = 1'b0; clr_start = 1'b0;
        #1;
        checks++;
        if (cpu_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_release_cycle got=%b exp=0", cpu_wr_ready);
        end
        next_cycle();
        #1;
        checks++;
        if (cpu_wr_ready !== 1'b1 || ram_en !== 1'b0 || clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset ready=%b ram_en=%b busy=%b exp 1/0/0",
                     cpu_wr_ready, ram_en, clr_busy);
        end
        $display("reset: done, cpu_wr_ready=%b", cpu_wr_ready);
    endtask

    task automatic test_single_write();
        logic seen;
        next_cycle();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'd5; cpu_wr_data = 8'h41;
        #1;
        checks++;
        if (cpu_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept ready got=%b exp=1", cpu_wr_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            next_cycle();
            cpu_wr_valid = 1'b0;
            #1;
            checks++;
            if (cpu_wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_ready_hold got=%b exp=1", cpu_wr_ready);
            end
            if (ram_en === 1'b1 && ram_we === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (ram_addr !== 13'd5 || ram_wdata !== 8'h41) begin
                    errors++;
                    $display("FAIL single_write got addr=%0d data=%h exp addr=5 data=41",
                             ram_addr, ram_wdata);
                end
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL single_write_timeout got no write exp write within 2 cycles");
        end
        ref_mem[5] = 8'h41;
        $display("single_write: addr=5 data=41 seen=%b", seen);
    endtask

    task automatic test_scanout_fill();
        int acc;
        logic exp_v, exp_rdy;
        logic [AW-1:0] pa;
        logic [7:0] pd;
        acc = 0;
        pa = AW'($urandom_range(0, N - 1));
        pd = 8'($urandom);
        for (int k = 0; k < 32; k++) begin
            next_cycle();
            disp_req     = (k < 20);
            disp_addr    = AW'($urandom_range(0, N - 1));
            cpu_wr_valid = (acc < 4);
            cpu_wr_addr  = pa;
            cpu_wr_data  = pd;
            #1;
            exp_v = (dq_due.size() > 0) && (dq_due[0] == cyc);
            checks++;
            if (disp_valid !== exp_v || (exp_v && disp_data !== dq_data[0])) begin
                errors++;
                $display("FAIL fill_disp cyc=%0d valid=%b data=%h exp valid=%b data=%h",
                         cyc, disp_valid, disp_data, exp_v, exp_v ? dq_data[0] : 8'h00);
            end
            if (exp_v) begin void'(dq_due.pop_front()); void'(dq_data.pop_front()); end
            exp_rdy = (wq_addr.size() < DEPTH);
            checks++;
            if (cpu_wr_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fill_ready cyc=%0d got=%b exp=%b", cyc, cpu_wr_ready, exp_rdy);
            end
            if (disp_req) begin
                checks++;
                if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, disp_addr}) begin
                    errors++;
                    $display("FAIL fill_fetch_grant cyc=%0d en=%b we=%b addr=%0d exp 1/0/%0d",
                             cyc, ram_en, ram_we, ram_addr, disp_addr);
                end
                dq_due.push_back(cyc + 2);
                dq_data.push_back(ref_mem[disp_addr]);
            end else if (wq_addr.size() > 0) begin
                checks++;
                if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, wq_addr[0], wq_data[0]}) begin
                    errors++;
                    $display("FAIL fill_retire cyc=%0d en=%b we=%b addr=%0d data=%h exp addr=%0d data=%h",
                             cyc, ram_en, ram_we, ram_addr, ram_wdata, wq_addr[0], wq_data[0]);
                end
                ref_mem[wq_addr[0]] = wq_data[0];
                void'(wq_addr.pop_front()); void'(wq_data.pop_front());
            end else begin
                checks++;
                if (ram_en !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_idle cyc=%0d ram_en=%b exp=0", cyc, ram_en);
                end
            end
            if (cpu_wr_valid && exp_rdy) begin
                wq_addr.push_back(pa); wq_data.push_back(pd);
                acc++;
                pa = AW'($urandom_range(0, N - 1));
                pd = 8'($urandom);
            end
        end
        cpu_wr_valid = 1'b0; disp_req = 1'b0;
        checks++;
        if (acc != 4 || wq_addr.size() != 0 || dq_due.size() != 0) begin
            errors++;
            $display("FAIL fill_drain accepted=%0d left_writes=%0d left_fetches=%0d exp 4/0/0",
                     acc, wq_addr.size(), dq_due.size());
        end
        $display("scanout_fill: accepted=%0d writes retired after scanout", acc);
    endtask

    task automatic test_drop();
        next_cycle();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'd4799; cpu_wr_data = 8'h55;
        #1;
        checks++;
        if (cpu_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_accept_4799 ready got=%b exp=1", cpu_wr_ready);
        end
        next_cycle();
        cpu_wr_addr = 13'd4800; cpu_wr_data = 8'h66;
        #1;
        checks++;
        if (cpu_wr_ready !== 1'b1 || cpu_wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_in_range ready=%b drop=%b exp 1/0", cpu_wr_ready, cpu_wr_drop);
        end
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 13'd4799, 8'h55}) begin
            errors++;
            $display("FAIL drop_write_4799 en=%b we=%b addr=%0d data=%h exp 1/1/4799/55",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        ref_mem[4799] = 8'h55;
        next_cycle();
        cpu_wr_valid = 1'b0;
        #1;
        checks++;
        if (cpu_wr_drop !== 1'b1 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse drop=%b ram_en=%b exp 1/0", cpu_wr_drop, ram_en);
        end
        next_cycle();
        #1;
        checks++;
        if (cpu_wr_drop !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL drop_end drop=%b ram_en=%b exp 0/0", cpu_wr_drop, ram_en);
        end
        $display("drop: addr 4799 written, addr 4800 dropped");
    endtask

    task automatic test_back_to_back();
        logic exp_v, exp_rdy, exp_drop, have;
        logic [AW-1:0] pa;
        logic [7:0] pd;
        exp_drop = 1'b0;
        have = 1'b0;
        pa = '0;
        pd = '0;
        for (int k = 0; k < 330; k++) begin
            next_cycle();
            if (!have) begin
                pa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(N, MEMSZ - 1))
                                                 : AW'($urandom_range(0, N - 1));
                pd = 8'($urandom);
                have = 1'b1;
            end
            disp_req     = (k < 300) && ($urandom_range(0, 4) < 2);
            disp_addr    = AW'($urandom_range(0, N - 1));
            cpu_wr_valid = (k < 300) && ($urandom_range(0, 2) != 0);
            cpu_wr_addr  = pa;
            cpu_wr_data  = pd;
            #1;
            exp_v = (dq_due.size() > 0) && (dq_due[0] == cyc);
            checks++;
            if (disp_valid !== exp_v || (exp_v && disp_data !== dq_data[0])) begin
                errors++;
                $display("FAIL b2b_disp cyc=%0d valid=%b data=%h exp valid=%b data=%h",
                         cyc, disp_valid, disp_data, exp_v, exp_v ? dq_data[0] : 8'h00);
            end
            if (exp_v) begin void'(dq_due.pop_front()); void'(dq_data.pop_front()); end
            exp_rdy = (wq_addr.size() < DEPTH);
            checks++;
            if (cpu_wr_ready !== exp_rdy || cpu_wr_drop !== exp_drop) begin
                errors++;
                $display("FAIL b2b_handshake cyc=%0d ready=%b drop=%b exp ready=%b drop=%b",
                         cyc, cpu_wr_ready, cpu_wr_drop, exp_rdy, exp_drop);
            end
            if (disp_req) begin
                checks++;
                if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, disp_addr}) begin
                    errors++;
                    $display("FAIL b2b_fetch_grant cyc=%0d en=%b we=%b addr=%0d exp 1/0/%0d",
                             cyc, ram_en, ram_we, ram_addr, disp_addr);
                end
                dq_due.push_back(cyc + 2);
                dq_data.push_back(ref_mem[disp_addr]);
            end else if (wq_addr.size() > 0) begin
                checks++;
                if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, wq_addr[0], wq_data[0]}) begin
                    errors++;
                    $display("FAIL b2b_retire cyc=%0d en=%b we=%b addr=%0d data=%h exp addr=%0d data=%h",
                             cyc, ram_en, ram_we, ram_addr, ram_wdata, wq_addr[0], wq_data[0]);
                end
                ref_mem[wq_addr[0]] = wq_data[0];
                void'(wq_addr.pop_front()); void'(wq_data.pop_front());
            end else begin
                checks++;
                if (ram_en !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle cyc=%0d ram_en=%b exp=0", cyc, ram_en);
                end
            end
            exp_drop = 1'b0;
            if (cpu_wr_valid && exp_rdy) begin
                if (int'(pa) < N) begin
                    wq_addr.push_back(pa); wq_data.push_back(pd);
                end else begin
                    exp_drop = 1'b1;
                end
                have = 1'b0;
            end
        end
        checks++;
        if (wq_addr.size() != 0 || dq_due.size() != 0 || exp_drop !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain left_writes=%0d left_fetches=%0d exp 0/0",
                     wq_addr.size(), dq_due.size());
        end
        $display("back_to_back: 300 random cycles with scanout, writes and drops");
    endtask

    task automatic test_clear();
        int busy, bad, first_bad, n;
        logic done;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            disp_req     = 1'b1;
            disp_addr    = AW'($urandom_range(0, N - 1));
            cpu_wr_valid = (k < 3);
            cpu_wr_addr  = AW'($urandom_range(0, N - 1));
            cpu_wr_data  = 8'($urandom);
            clr_start    = (k == 3);
            clr_char     = 8'h20;
            #1;
        end
        busy = 0; bad = 0; first_bad = -1; done = 1'b0;
        for (n = 0; n < 6000 && !done; n++) begin
            next_cycle();
            disp_req     = 1'b0;
            clr_start    = (n == 50);
            clr_char     = (n == 50) ? 8'h77 : 8'h20;
            cpu_wr_valid = (n < 4000) && ($urandom_range(0, 1) == 1);
            cpu_wr_addr  = AW'($urandom_range(0, N - 1));
            #1;
            if (clr_busy !== 1'b1) begin
                done = 1'b1;
            end else begin
                if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, AW'(busy), 8'h20} ||
                    cpu_wr_ready !== 1'b0) begin
                    bad++;
                    if (first_bad < 0) first_bad = busy;
                end
                busy++;
            end
        end
        checks++;
        if (done !== 1'b1 || busy != N) begin
            errors++;
            $display("FAIL clear_busy_cycles got=%0d exp=%0d", busy, N);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_sweep bad_cycles=%0d first_at=%0d exp=0", bad, first_bad);
        end
        checks++;
        if (cpu_wr_ready !== 1'b1 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_end ready=%b ram_en=%b exp 1/0", cpu_wr_ready, ram_en);
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #1;
            if (ram_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_flush stale_writes=%0d exp=0", bad);
        end
        for (int i = 0; i < N; i++) ref_mem[i] = 8'h20;
        $display("clear: busy=%0d cycles, fill=20, FIFO flushed", busy);
    endtask

    task automatic test_clear_interleave();
        int len, f, w, wdone, busy, s_bad, d_bad;
        logic exp_v;
        logic [7:0] ch;
        len = 0; f = 0; w = 0;
        while (w < N) begin
            if (len % 8 == 0) f++;
            else w++;
            len++;
        end
        ch = 8'($urandom);
        next_cycle();
        clr_start = 1'b1; clr_char = ch; disp_req = 1'b0; cpu_wr_valid = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL ileave_start_busy got=%b exp=0", clr_busy);
        end
        wdone = 0; busy = 0; s_bad = 0; d_bad = 0;
        for (int n = 0; n < len + 4; n++) begin
            next_cycle();
            clr_start = 1'b0;
            disp_req  = (n < len) && (n % 8 == 0);
            disp_addr = AW'($urandom_range(0, N - 1));
            #1;
            exp_v = (dq_due.size() > 0) && (dq_due[0] == cyc);
            if (disp_valid !== exp_v || (exp_v && disp_data !== dq_data[0])) d_bad++;
            if (exp_v) begin void'(dq_due.pop_front()); void'(dq_data.pop_front()); end
            if (clr_busy !== (wdone < N)) s_bad++;
            if (clr_busy === 1'b1) busy++;
            if (disp_req) begin
                if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, disp_addr}) s_bad++;
                dq_due.push_back(cyc + 2);
                dq_data.push_back((int'(disp_addr) < wdone) ? ch : ref_mem[disp_addr]);
            end else if (wdone < N) begin
                if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, AW'(wdone), ch}) s_bad++;
                wdone++;
            end else if (ram_en !== 1'b0) begin
                s_bad++;
            end
        end
        checks++;
        if (busy != N + f) begin
            errors++;
            $display("FAIL ileave_busy_cycles got=%0d exp=%0d", busy, N + f);
        end
        checks++;
        if (s_bad != 0) begin
            errors++;
            $display("FAIL ileave_grant bad_cycles=%0d exp=0", s_bad);
        end
        checks++;
        if (d_bad != 0 || dq_due.size() != 0) begin
            errors++;
            $display("FAIL ileave_fetch bad=%0d left=%0d exp 0/0", d_bad, dq_due.size());
        end
        for (int i = 0; i < N; i++) ref_mem[i] = ch;
        $display("clear_interleave: fill=%h fetches=%0d busy=%0d", ch, f, busy);
    endtask

    task automatic test_memory_image();
        int bad, first;
        bad = 0; first = -1;
        for (int i = 0; i < MEMSZ; i++) begin
            if (ram_mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL memory_image mismatches=%0d first_addr=%0d got=%h exp=%h",
                     bad, first, ram_mem[(first < 0) ? 0 : first], ref_mem[(first < 0) ? 0 : first]);
        end
        $display("memory_image: %0d bytes compared", MEMSZ);
    endtask

    task automatic test_reset_midsweep();
        logic hit;
        int bad;
        next_cycle();
        clr_start = 1'b1; clr_char = 8'hAA; disp_req = 1'b0; cpu_wr_valid = 1'b0;
        #1;
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            next_cycle();
            clr_start = 1'b0;
            #1;
            if (ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === 13'd100) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_reach got no write to 100 exp write to 100");
        end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || ram_en !== 1'b0 || cpu_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_abort busy=%b ram_en=%b ready=%b exp 0/0/0",
                     clr_busy, ram_en, cpu_wr_ready);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1;
            if (cpu_wr_ready !== 1'b1 || ram_en !== 1'b0 || clr_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midsweep_recover bad_cycles=%0d exp=0", bad);
        end
        $display("reset_midsweep: aborted at address 100");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d exp finish before timeout", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_byte(i);
        test_reset();
        test_single_write();
        test_scanout_fill();
        test_drop();
        test_back_to_back();
        test_clear();
        test_clear_interleave();
        test_memory_image();
        test_reset_midsweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
